// File: rtl/job_dispatcher.sv
// ----------------------------------------------------------------------------
// job_dispatcher
//
// Collects 32-bit operand words into 8-word jobs. A two-slot (ping-pong)
// operand buffer lets the next job load while the current one is being
// computed. A small FSM hands each complete job to an external compute core,
// waits for its completion (with a timeout), and queues the core result in a
// result FIFO for the consumer.
//
// Parameters
//   TIMEOUT    max cycles spent in WAIT for core_done before abandoning a job
//   RES_DEPTH  result FIFO depth in entries (power of two, >= 2)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   wr_valid/wr_data/wr_ready  operand word input (valid/ready)
//   core_start                 one-cycle start pulse to the compute core
//   core_i1..core_i8           job operands, stable from START until job ends
//   core_result/core_done      core completion and its result
//   res_valid/res_data/res_ready  result FIFO head (valid/ready)
//   busy                       FSM is not IDLE
//   timeout_err                sticky: a job was abandoned on timeout
//   jobs_done                  completed-job counter (wraps)
// ----------------------------------------------------------------------------
module job_dispatcher #(
  parameter int TIMEOUT   = 1024,
  parameter int RES_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  output logic        core_start,
  output logic [31:0] core_i1,
  output logic [31:0] core_i2,
  output logic [31:0] core_i3,
  output logic [31:0] core_i4,
  output logic [31:0] core_i5,
  output logic [31:0] core_i6,
  output logic [31:0] core_i7,
  output logic [31:0] core_i8,
  input  logic [31:0] core_result,
  input  logic        core_done,
  output logic        res_valid,
  output logic [31:0] res_data,
  input  logic        res_ready,
  output logic        busy,
  output logic        timeout_err,
  output logic [15:0] jobs_done
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int AW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, STORE} state_t;

  state_t        state, next_state;

  // Operand buffer: two job slots of eight words each.
  logic [31:0]   op_buf [2][8];
  logic [1:0]    slot_full;
  logic          wr_slot;
  logic          rd_slot;
  logic [2:0]    word_cnt;
  logic          wr_fire;
  logic          slot_free;
  logic          timeout_hit;

  logic [TW-1:0] wait_cnt;
  logic [31:0]   result_q;
  logic [31:0]   core_ops [8];

  // Result FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [31:0]   fifo_mem [RES_DEPTH];
  logic [AW:0]   fifo_wr_ptr;
  logic [AW:0]   fifo_rd_ptr;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  assign wr_fire     = wr_valid && wr_ready;
  assign timeout_hit = (state == WAIT) && !core_done && (wait_cnt == TW'(TIMEOUT - 1));
  // A job leaves the read slot either by completing (STORE) or by timing out.
  assign slot_free   = (state == STORE) || timeout_hit;

  assign fifo_empty  = (fifo_wr_ptr == fifo_rd_ptr);
  assign fifo_full   = (fifo_wr_ptr[AW] != fifo_rd_ptr[AW]) &&
                       (fifo_wr_ptr[AW-1:0] == fifo_rd_ptr[AW-1:0]);
  // IDLE only dispatches when the FIFO has room, so STORE never sees it full;
  // the guard simply keeps the FIFO safe by construction.
  assign push        = (state == STORE) && !fifo_full;
  assign pop         = res_ready && !fifo_empty;

  // --------------------------------------------------------------------------
  // Operand storage (data only)
  // --------------------------------------------------------------------------
  // NOTE: data arrays carry no reset; the slot_full/word_cnt control bits
  // decide whether their contents are meaningful.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      op_buf[wr_slot][word_cnt] <= wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // Slot bookkeeping. A freeing read slot and a filling write slot are always
  // different slots, so both updates can land in the same cycle.
  // --------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // registers update together from values sampled before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_full <= 2'b00;
      wr_slot   <= 1'b0;
      rd_slot   <= 1'b0;
      word_cnt  <= 3'd0;
    end else begin
      if (wr_fire) begin
        word_cnt <= word_cnt + 3'd1;
        if (word_cnt == 3'd7) begin
          slot_full[wr_slot] <= 1'b1;
          wr_slot            <= ~wr_slot;
        end
      end
      if (slot_free) begin
        slot_full[rd_slot] <= 1'b0;
        rd_slot            <= ~rd_slot;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic. core_done is looked at only in WAIT.
  // --------------------------------------------------------------------------
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (slot_full[rd_slot] && !fifo_full) next_state = START;
      START:   next_state = WAIT;
      WAIT: begin
        if (core_done)        next_state = STORE;
        else if (timeout_hit) next_state = IDLE;
      end
      STORE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. Operands are driven straight from the read slot, which
  // cannot be written while it holds the job in flight.
  // --------------------------------------------------------------------------
  always_comb begin
    core_start = (state == START);
    busy       = (state != IDLE);
    wr_ready   = !slot_full[wr_slot];
    res_valid  = !fifo_empty;
    res_data   = fifo_empty ? 32'd0 : fifo_mem[fifo_rd_ptr[AW-1:0]];
    for (int k = 0; k < 8; k++) begin
      core_ops[k] = (state != IDLE) ? op_buf[rd_slot][k] : 32'd0;
    end
  end

  assign core_i1 = core_ops[0];
  assign core_i2 = core_ops[1];
  assign core_i3 = core_ops[2];
  assign core_i4 = core_ops[3];
  assign core_i5 = core_ops[4];
  assign core_i6 = core_ops[5];
  assign core_i7 = core_ops[6];
  assign core_i8 = core_ops[7];

  // --------------------------------------------------------------------------
  // Job datapath: WAIT cycle counter, result latch, status.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      result_q    <= 32'd0;
      timeout_err <= 1'b0;
      jobs_done   <= 16'd0;
    end else begin
      if (state == START) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + TW'(1);
      end
      if ((state == WAIT) && core_done) begin
        result_q <= core_result;
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
      if (state == STORE) begin
        jobs_done <= jobs_done + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Result FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[fifo_wr_ptr[AW-1:0]] <= result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_ptr <= '0;
      fifo_rd_ptr <= '0;
    end else begin
      if (push) fifo_wr_ptr <= fifo_wr_ptr + (AW+1)'(1);
      if (pop)  fifo_rd_ptr <= fifo_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_job_dispatcher.sv
// ----------------------------------------------------------------------------
// tb_job_dispatcher
//
// Directed bench for job_dispatcher (TIMEOUT=16, RES_DEPTH=4). A behavioural
// compute core returns the sum of its eight operands core_lat cycles after
// the start pulse. Inputs are driven on the falling edge; a monitor samples
// outputs 2 ns after the falling edge.
// ----------------------------------------------------------------------------
module tb_job_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = 32'd0;
  logic        wr_ready;
  logic        core_start;
  logic [31:0] core_i1, core_i2, core_i3, core_i4, core_i5, core_i6, core_i7, core_i8;
  logic [31:0] core_result;
  logic        core_done;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready = 1'b0;
  logic        busy;
  logic        timeout_err;
  logic [15:0] jobs_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  job_dispatcher #(.TIMEOUT(16), .RES_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .core_start(core_start),
    .core_i1(core_i1), .core_i2(core_i2), .core_i3(core_i3), .core_i4(core_i4),
    .core_i5(core_i5), .core_i6(core_i6), .core_i7(core_i7), .core_i8(core_i8),
    .core_result(core_result), .core_done(core_done),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .busy(busy), .timeout_err(timeout_err), .jobs_done(jobs_done)
  );

  // Behavioural compute core.
  bit          core_en = 1'b1;
  int          core_lat = 5;
  int          core_cnt = 0;
  logic        model_done = 1'b0;
  logic        spurious_done = 1'b0;
  logic [31:0] model_sum = 32'd0;
  logic [31:0] model_result = 32'd0;

  assign core_done   = model_done | spurious_done;
  assign core_result = model_result;

  always @(negedge clk) begin
    model_done = 1'b0;
    if (core_cnt > 0) begin
      core_cnt = core_cnt - 1;
      if (core_cnt == 0) begin
        model_done   = 1'b1;
        model_result = model_sum;
      end
    end
    if (core_start === 1'b1 && core_en) begin
      core_cnt  = core_lat;
      model_sum = core_i1 + core_i2 + core_i3 + core_i4 + core_i5 + core_i6 + core_i7 + core_i8;
    end
  end

  // Monitor: start pulses and accepted results.
  int          cyc = 0;
  int          start_cnt = 0;
  int          start_cyc[$];
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc++;

  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (core_start === 1'b1) begin
        start_cnt++;
        start_cyc.push_back(cyc);
      end
      if (res_valid === 1'b1 && res_ready === 1'b1) got_q.push_back(res_data);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic send_word(input logic [31:0] d);
    int t = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    while (wr_ready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (wr_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL send_word_timeout: wr_ready stayed %0b, required 1", wr_ready);
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic send_job(input logic [31:0] w [8]);
    logic [31:0] s = 32'd0;
    for (int i = 0; i < 8; i++) begin
      send_word(w[i]);
      s += w[i];
    end
    exp_q.push_back(s);
  endtask

  task automatic wait_start_pulse(input string name);
    int t = 0;
    while (core_start !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (core_start !== 1'b1) begin
      failures++;
      $display("FAIL %s: core_start never seen, got %0b required 1", name, core_start);
    end
  endtask

  task automatic wait_starts(input int n, input string name);
    int t = 0;
    while (start_cnt < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (start_cnt < n) begin
      failures++;
      $display("FAIL %s: start count %0d, required %0d", name, start_cnt, n);
    end
  endtask

  task automatic wait_results(input int n, input string name);
    int t = 0;
    while (got_q.size() < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (got_q.size() < n) begin
      failures++;
      $display("FAIL %s: results received %0d, required %0d", name, got_q.size(), n);
    end
  endtask

  task automatic wait_res_valid(input string name);
    int t = 0;
    while (res_valid !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (res_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s: res_valid got %0b required 1", name, res_valid);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL %s_wr_ready: got %0b required 1", tag, wr_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s_busy: got %0b required 0", tag, busy); end
    checks++; if (core_start !== 1'b0) begin failures++; $display("FAIL %s_core_start: got %0b required 0", tag, core_start); end
    checks++; if ({core_i1, core_i2, core_i3, core_i4, core_i5, core_i6, core_i7, core_i8} !== 256'd0) begin
      failures++; $display("FAIL %s_core_i: got %h required 0", tag, {core_i1, core_i8});
    end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL %s_res_valid: got %0b required 0", tag, res_valid); end
    checks++; if (res_data !== 32'd0) begin failures++; $display("FAIL %s_res_data: got %h required 0", tag, res_data); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL %s_timeout_err: got %0b required 0", tag, timeout_err); end
    checks++; if (jobs_done !== 16'd0) begin failures++; $display("FAIL %s_jobs_done: got %0d required 0", tag, jobs_done); end
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_job();
    logic [31:0] w [8] = '{32'd3, 32'd2, 32'd6, 32'd4, 32'd2, 32'd3, 32'd3, 32'd1};
    logic [31:0] ops [8];
    res_ready = 1'b0;
    send_job(w);
    wait_start_pulse("single_start");
    ops = '{core_i1, core_i2, core_i3, core_i4, core_i5, core_i6, core_i7, core_i8};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ops[i] !== w[i]) begin failures++; $display("FAIL single_core_i%0d: got %0d required %0d", i + 1, ops[i], w[i]); end
    end
    @(negedge clk);
    checks++; if (core_start !== 1'b0) begin failures++; $display("FAIL single_pulse_width: core_start got %0b required 0", core_start); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %0b required 1", busy); end
    repeat (3) @(negedge clk);
    checks++; if (core_i3 !== 32'd6 || core_i8 !== 32'd1) begin
      failures++; $display("FAIL single_core_i_stable: got i3=%0d i8=%0d required 6 1", core_i3, core_i8);
    end
    wait_res_valid("single_res_valid");
    checks++; if (res_data !== 32'd24) begin failures++; $display("FAIL single_res_data: got %0d required 24", res_data); end
    @(negedge clk);
    checks++; if (jobs_done !== 16'd1) begin failures++; $display("FAIL single_jobs_done: got %0d required 1", jobs_done); end
    checks++; if (start_cnt !== 1) begin failures++; $display("FAIL single_start_count: got %0d required 1", start_cnt); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_pop_empty: res_valid got %0b required 0", res_valid); end
    checks++; if (got_q.size() != 1 || got_q[0] !== 32'd24) begin
      failures++; $display("FAIL single_popped: got %0d entries required one of value 24", got_q.size());
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int s0 = start_cyc.size();
    int base = start_cnt;
    res_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      checks++;
      if (wr_ready !== 1'b1) begin failures++; $display("FAIL b2b_wr_ready word %0d: got %0b required 1", j + 1, wr_ready); end
      send_word((j < 8) ? 32'(j + 1) : 32'(j + 2));
    end
    wait_starts(base + 2, "b2b_two_starts");
    wait_results(2, "b2b_results");
    if (got_q.size() >= 2) begin
      checks++; if (got_q[0] !== 32'd36) begin failures++; $display("FAIL b2b_result0: got %0d required 36", got_q[0]); end
      checks++; if (got_q[1] !== 32'd108) begin failures++; $display("FAIL b2b_result1: got %0d required 108", got_q[1]); end
    end
    if (start_cyc.size() >= s0 + 2) begin
      checks++;
      if (start_cyc[s0 + 1] - start_cyc[s0] != 8) begin
        failures++; $display("FAIL b2b_start_to_start: got %0d cycles required 8", start_cyc[s0 + 1] - start_cyc[s0]);
      end
    end
    checks++; if (jobs_done !== 16'd3) begin failures++; $display("FAIL b2b_jobs_done: got %0d required 3", jobs_done); end
    res_ready = 1'b0;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [31:0] w [8];
    int base = start_cnt;
    res_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 8; i++) w[i] = 32'(k * 16 + i * 3 + 7);
      send_job(w);
    end
    repeat (30) @(negedge clk);
    checks++; if (start_cnt - base != 4) begin failures++; $display("FAIL bp_starts_held: got %0d required 4", start_cnt - base); end
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL bp_res_valid: got %0b required 1", res_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_idle: busy got %0b required 0", busy); end
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL bp_slots_full: wr_ready got %0b required 0", wr_ready); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL bp_single_pop: got %0d required 1", got_q.size()); end
    wait_starts(base + 5, "bp_fifth_start");
    res_ready = 1'b1;
    wait_results(6, "bp_results");
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_result%0d: got %0d required %0d", i, got_q[i], exp_q[i]); end
      end
    end
    @(negedge clk);
    checks++; if (jobs_done !== 16'd9) begin failures++; $display("FAIL bp_jobs_done: got %0d required 9", jobs_done); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout();
    logic [31:0] w [8] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
    logic [31:0] w2 [8] = '{32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12};
    core_en = 1'b0;
    send_job(w);
    wait_start_pulse("to_start");
    repeat (16) @(negedge clk);
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_early: timeout_err got %0b required 0", timeout_err); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL to_still_waiting: busy got %0b required 1", busy); end
    @(negedge clk);
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_flag: timeout_err got %0b required 1", timeout_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL to_idle: busy got %0b required 0", busy); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL to_no_push: res_valid got %0b required 0", res_valid); end
    checks++; if (jobs_done !== 16'd9) begin failures++; $display("FAIL to_jobs_done: got %0d required 9", jobs_done); end
    core_en = 1'b1;
    exp_q.delete();
    res_ready = 1'b1;
    send_job(w2);
    wait_results(1, "to_next_job");
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== 32'd68) begin failures++; $display("FAIL to_next_result: got %0d required 68", got_q[0]); end
    end
    @(negedge clk);
    checks++; if (jobs_done !== 16'd10) begin failures++; $display("FAIL to_next_jobs_done: got %0d required 10", jobs_done); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_sticky: got %0b required 1", timeout_err); end
    res_ready = 1'b0;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_spurious_done();
    logic [31:0] w [8] = '{32'd20, 32'd21, 32'd22, 32'd23, 32'd24, 32'd25, 32'd26, 32'd27};
    res_ready = 1'b1;
    spurious_done = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL sp_idle_push: results %0d required 0", got_q.size()); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sp_idle_busy: got %0b required 0", busy); end
    send_job(w);
    wait_start_pulse("sp_start");
    @(negedge clk);
    spurious_done = 1'b0;
    wait_results(1, "sp_result");
    repeat (10) @(negedge clk);
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL sp_result_count: got %0d required 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== 32'd188) begin failures++; $display("FAIL sp_result: got %0d required 188", got_q[0]); end
    end
    checks++; if (jobs_done !== 16'd11) begin failures++; $display("FAIL sp_jobs_done: got %0d required 11", jobs_done); end
    res_ready = 1'b0;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] wa [8] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2};
    logic [31:0] wb [8] = '{32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9};
    res_ready = 1'b0;
    send_job(wa);
    wait_res_valid("rst_preload");
    core_lat = 10;
    send_job(wb);
    wait_start_pulse("rst_start");
    @(negedge clk);
    for (int i = 0; i < 4; i++) send_word(32'd1000);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    core_lat = 5;
    repeat (8) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_late_done_busy: got %0b required 0", busy); end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL rst_late_done_push: results %0d required 0", got_q.size()); end
    checks++; if (jobs_done !== 16'd0) begin failures++; $display("FAIL rst_jobs_done: got %0d required 0", jobs_done); end
    for (int i = 0; i < 7; i++) send_word(32'(i + 40));
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_fresh_words: busy got %0b required 0 after 7 words", busy); end
    send_word(32'd47);
    wait_results(1, "rst_fresh_result");
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== 32'd348) begin failures++; $display("FAIL rst_fresh_value: got %0d required 348", got_q[0]); end
    end
    @(negedge clk);
    checks++; if (jobs_done !== 16'd1) begin failures++; $display("FAIL rst_fresh_jobs_done: got %0d required 1", jobs_done); end
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_spurious_done();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
